password_checker: RTL and testbench

- Password store and serial checker that sits directly downstream of the password setter.
- Holds the four 4-bit password digits, written through the setter's data/address/write-enable port.
- Compares a serial stream of entered digits against the stored digits and reports unlock, failure and alarm status to the display/LED stage.
- Counts consecutive failures, raises an alarm at the limit, and re-locks automatically after a timeout.

---
 rtl/password_checker_if.sv | 26 ++
 rtl/password_checker.sv | 149 ++++++++++++++
 tb/tb_password_checker.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/password_checker_if.sv
// Setter/keypad/display bundle for the password checker: write port, digit
// stream and user commands in, lock status and entry progress out.
interface password_checker_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       digit_valid;
    logic [3:0] digit;
    logic       relock;
    logic       admin_clear;
    logic       unlocked;
    logic       alarm;
    logic       fail_pulse;
    logic [3:0] fail_count;
    logic [1:0] digit_index;

    modport master (
        output wr_en, wr_addr, wr_data, digit_valid, digit, relock, admin_clear,
        input  unlocked, alarm, fail_pulse, fail_count, digit_index
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, digit_valid, digit, relock, admin_clear,
        output unlocked, alarm, fail_pulse, fail_count, digit_index
    );
endinterface

// File: rtl/password_checker.sv
// Four-digit password store with a serial digit checker, consecutive-failure
// alarm and timed automatic re-lock.
//
// state   | meaning
// C_IDLE  | waiting for first digit
// C_D1    | first digit taken, expecting slot 1
// C_D2    | expecting slot 2
// C_D3    | expecting slot 3
// C_EVAL  | one-cycle decision on the accumulated mismatch
// C_OPEN  | unlocked, open timer running
// C_ALARM | too many failures, waits for admin_clear
module password_checker #(
    parameter int MAX_FAILS    = 3,
    parameter int OPEN_TIMEOUT = 1000,
    parameter int TIMER_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    password_checker_if.slave bus
);

    typedef enum logic [2:0] {
        C_IDLE, C_D1, C_D2, C_D3, C_EVAL, C_OPEN, C_ALARM
    } state_t;

    localparam logic [TIMER_W-1:0] TIMER_LAST =
        (OPEN_TIMEOUT == 0) ? '0 : TIMER_W'(OPEN_TIMEOUT - 1);
    localparam logic [4:0] FAIL_LIMIT = 5'(MAX_FAILS);

    state_t             state, state_nx;
    logic [3:0]         slot [4];
    logic               mismatch, mismatch_nx;
    logic [3:0]         fail_count, fail_count_nx;
    logic               fail_pulse, fail_pulse_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic [1:0]         digit_index;
    logic [4:0]         fail_inc;
    logic               digit_wrong;

    always_comb begin
        digit_index = 2'd0;
        case (state)
            C_D1:    digit_index = 2'd1;
            C_D2:    digit_index = 2'd2;
            C_D3:    digit_index = 2'd3;
            default: digit_index = 2'd0;
        endcase
    end

    // The slot is read before this edge's write lands, so a same-cycle write compares against the old digit.
    assign digit_wrong = (bus.digit != slot[digit_index]);
    assign fail_inc    = {1'b0, fail_count} + 5'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) slot[i] <= '0;
        end else if (bus.wr_en) begin
            slot[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= C_IDLE;
            mismatch   <= 1'b0;
            fail_count <= '0;
            fail_pulse <= 1'b0;
            timer      <= '0;
        end else begin
            state      <= state_nx;
            mismatch   <= mismatch_nx;
            fail_count <= fail_count_nx;
            fail_pulse <= fail_pulse_nx;
            timer      <= timer_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        mismatch_nx   = mismatch;
        fail_count_nx = fail_count;
        fail_pulse_nx = 1'b0;
        timer_nx      = timer;

        if (bus.admin_clear) fail_count_nx = '0;

        case (state)
            C_IDLE: begin
                if (bus.digit_valid) begin
                    mismatch_nx = digit_wrong;
                    state_nx    = C_D1;
                end
            end
            C_D1: begin
                if (bus.digit_valid) begin
                    mismatch_nx = mismatch | digit_wrong;
                    state_nx    = C_D2;
                end
            end
            C_D2: begin
                if (bus.digit_valid) begin
                    mismatch_nx = mismatch | digit_wrong;
                    state_nx    = C_D3;
                end
            end
            C_D3: begin
                if (bus.digit_valid) begin
                    mismatch_nx = mismatch | digit_wrong;
                    state_nx    = C_EVAL;
                end
            end
            C_EVAL: begin
                mismatch_nx = 1'b0;
                if (!mismatch) begin
                    fail_count_nx = '0;
                    timer_nx      = '0;
                    state_nx      = C_OPEN;
                end else begin
                    fail_pulse_nx = 1'b1;
                    if (!bus.admin_clear)
                        fail_count_nx = (fail_count == 4'hF) ? 4'hF : fail_inc[3:0];
                    // A clear arriving with the failing verdict also blocks the alarm.
                    if (!bus.admin_clear && (fail_inc >= FAIL_LIMIT))
                        state_nx = C_ALARM;
                    else
                        state_nx = C_IDLE;
                end
            end
            C_OPEN: begin
                timer_nx = timer + TIMER_W'(1);
                if (bus.relock || ((OPEN_TIMEOUT != 0) && (timer == TIMER_LAST))) begin
                    timer_nx = '0;
                    state_nx = C_IDLE;
                end
            end
            C_ALARM: begin
                if (bus.admin_clear) state_nx = C_IDLE;
            end
            default: state_nx = C_IDLE;
        endcase
    end

    assign bus.unlocked    = (state == C_OPEN);
    assign bus.alarm       = (state == C_ALARM);
    assign bus.fail_pulse  = fail_pulse;
    assign bus.fail_count  = fail_count;
    assign bus.digit_index = digit_index;

endmodule

// File: tb/tb_password_checker.sv
// Directed bench for password_checker: an entry-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_password_checker;
    localparam int MAX_FAILS    = 3;
    localparam int OPEN_TIMEOUT = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    password_checker_if bus();

    password_checker #(
        .MAX_FAILS(MAX_FAILS),
        .OPEN_TIMEOUT(OPEN_TIMEOUT),
        .TIMER_W(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: password, entry position, whether any digit so far was wrong.
    int m_pw [4]      = '{0, 0, 0, 0};
    int m_pos         = 0;
    bit m_wrong       = 0;
    bit m_eval        = 0;
    bit m_open        = 0;
    int m_open_cycles = 0;
    bit m_alarm       = 0;
    int m_fails       = 0;
    bit m_pulse       = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge CLK or posedge RST);
        if (RST) begin
            m_pw = '{0, 0, 0, 0};
            m_pos = 0; m_wrong = 0; m_eval = 0; m_open = 0; m_open_cycles = 0;
            m_alarm = 0; m_fails = 0; m_pulse = 0;
        end else begin
            bit pulse;
            pulse = 0;
            if (m_alarm) begin
                if (bus.admin_clear) begin
                    m_alarm = 0;
                    m_fails = 0;
                end
            end else if (m_open) begin
                m_open_cycles++;
                if (bus.admin_clear) m_fails = 0;
                if (bus.relock || (OPEN_TIMEOUT != 0 && m_open_cycles == OPEN_TIMEOUT))
                    m_open = 0;
            end else if (m_eval) begin
                m_eval = 0;
                if (!m_wrong) begin
                    m_fails = 0;
                    m_open = 1;
                    m_open_cycles = 0;
                end else begin
                    pulse = 1;
                    if (bus.admin_clear) m_fails = 0;
                    else begin
                        m_fails = (m_fails + 1 > 15) ? 15 : m_fails + 1;
                        if (m_fails >= MAX_FAILS) m_alarm = 1;
                    end
                end
            end else begin
                if (bus.admin_clear) m_fails = 0;
                if (bus.digit_valid) begin
                    if (m_pos == 0) m_wrong = 0;
                    if (int'(bus.digit) != m_pw[m_pos]) m_wrong = 1;
                    m_pos++;
                    if (m_pos == 4) begin
                        m_pos = 0;
                        m_eval = 1;
                    end
                end
            end
            m_pulse = pulse;
            if (bus.wr_en) m_pw[bus.wr_addr] = int'(bus.wr_data);
        end
    end

    initial forever begin
        @(negedge CLK);
        chk("m_unlocked",    int'(bus.unlocked),    int'(m_open));
        chk("m_alarm",       int'(bus.alarm),       int'(m_alarm));
        chk("m_fail_pulse",  int'(bus.fail_pulse),  int'(m_pulse));
        chk("m_fail_count",  int'(bus.fail_count),  m_fails);
        chk("m_digit_index", int'(bus.digit_index), (m_open || m_alarm || m_eval) ? 0 : m_pos);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_slot(input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'(addr);
        bus.wr_data = 4'(data);
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic strobe(input int d);
        bus.digit_valid = 1'b1;
        bus.digit       = 4'(d);
        step();
        bus.digit_valid = 1'b0;
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        strobe(a); strobe(b); strobe(c); strobe(d);
    endtask

    // Called right after the 4th strobe edge: closed during C_EVAL, open one cycle later.
    task automatic expect_unlock(input string tag);
        chk({tag, "_eval_closed"}, int'(bus.unlocked), 0);
        step();
        chk({tag, "_unlocked"}, int'(bus.unlocked), 1);
        chk({tag, "_count0"}, int'(bus.fail_count), 0);
    endtask

    task automatic do_relock();
        bus.relock = 1'b1;
        step();
        bus.relock = 1'b0;
    endtask

    task automatic wrong_entry(input string tag, input int exp_count);
        enter4(3, 7, 1, 8);
        step();
        chk({tag, "_pulse"}, int'(bus.fail_pulse), 1);
        chk({tag, "_count"}, int'(bus.fail_count), exp_count);
        chk({tag, "_locked"}, int'(bus.unlocked), 0);
        chk({tag, "_index"}, int'(bus.digit_index), 0);
    endtask

    initial begin
        int n;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.digit_valid = 0; bus.digit = 0; bus.relock = 0; bus.admin_clear = 0;

        step(); step();
        chk("rst_unlocked", int'(bus.unlocked), 0);
        chk("rst_alarm", int'(bus.alarm), 0);
        chk("rst_fail_pulse", int'(bus.fail_pulse), 0);
        chk("rst_fail_count", int'(bus.fail_count), 0);
        chk("rst_digit_index", int'(bus.digit_index), 0);
        RST = 1'b0;
        step();

        write_slot(0, 3); write_slot(1, 7); write_slot(2, 1); write_slot(3, 9);
        strobe(3);
        chk("index_after_1", int'(bus.digit_index), 1);
        strobe(7); strobe(1); strobe(9);
        expect_unlock("first");
        n = 0;
        for (int i = 0; i < 20 && bus.unlocked; i++) begin
            n++;
            step();
        end
        chk("timeout_len", n, 5);

        wrong_entry("wrong1", 1);
        step();
        chk("wrong1_pulse_one_cycle", int'(bus.fail_pulse), 0);
        wrong_entry("wrong2", 2);
        step();
        wrong_entry("wrong3", 3);
        chk("alarm_raised", int'(bus.alarm), 1);
        enter4(3, 7, 1, 9);
        step(); step();
        chk("alarm_ignores_entry", int'(bus.unlocked), 0);
        chk("alarm_held", int'(bus.alarm), 1);
        bus.admin_clear = 1'b1;
        step();
        bus.admin_clear = 1'b0;
        chk("clear_alarm", int'(bus.alarm), 0);
        chk("clear_count", int'(bus.fail_count), 0);
        enter4(3, 7, 1, 9);
        expect_unlock("after_clear");

        step();
        do_relock();
        chk("relock_closed", int'(bus.unlocked), 0);
        step();

        strobe(3); strobe(7);
        bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 4'd4;
        strobe(1);
        bus.wr_en = 1'b0;
        strobe(9);
        expect_unlock("same_cycle_write");
        do_relock();
        wrong_entry("old_digit", 1);
        step();
        enter4(3, 7, 4, 9);
        expect_unlock("new_digit");
        do_relock();

        wrong_entry("pre_mid_clear", 1);
        step();
        strobe(3); strobe(7);
        bus.admin_clear = 1'b1;
        step();
        bus.admin_clear = 1'b0;
        chk("mid_clear_count", int'(bus.fail_count), 0);
        chk("mid_clear_index", int'(bus.digit_index), 2);
        strobe(4); strobe(9);
        expect_unlock("mid_clear");
        do_relock();

        wrong_entry("eval_a", 1);
        step();
        wrong_entry("eval_b", 2);
        step();
        enter4(0, 0, 0, 0);
        bus.admin_clear = 1'b1;
        step();
        bus.admin_clear = 1'b0;
        chk("eval_clear_pulse", int'(bus.fail_pulse), 1);
        chk("eval_clear_no_alarm", int'(bus.alarm), 0);
        chk("eval_clear_count", int'(bus.fail_count), 0);
        step();

        strobe(3); strobe(7);
        #2 RST = 1'b1;
        #1;
        chk("rst_mid_index", int'(bus.digit_index), 0);
        step(); step();
        RST = 1'b0;
        step();
        enter4(0, 0, 0, 0);
        expect_unlock("zero_pw");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
